// File: rtl/ps2_key_rx_if.sv
// ps2_key_rx_if: decoded keyboard bus produced by the PS/2 receiver.
// The master drives the key word and strobes; consumers attach as slave.
interface ps2_key_rx_if;
   logic [10:0] ps2_key;
   logic        key_strobe;
   logic [7:0]  rx_byte;
   logic        rx_strobe;
   logic        frame_err;

   modport master (
      output ps2_key,
      output key_strobe,
      output rx_byte,
      output rx_strobe,
      output frame_err
   );

   modport slave (
      input ps2_key,
      input key_strobe,
      input rx_byte,
      input rx_strobe,
      input frame_err
   );
endinterface

// File: rtl/ps2_key_rx.sv
// ps2_key_rx: receives the raw PS/2 keyboard stream, decodes 11-bit frames
// and folds the E0/F0 prefixes into the 11-bit ps2_key word:
// [10] toggle, [9] pressed, [8] extended, [7:0] scancode.
module ps2_key_rx #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 100000
) (
   input  logic         clk_sys,
   input  logic         reset_n,
   input  logic         ps2_clk_in,
   input  logic         ps2_data_in,
   ps2_key_rx_if.master key_if
);

   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   // Odd parity over the eight data bits plus the received parity bit.
   function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
      return ^{d, p};
   endfunction

   // Line conditioning: index 0 is the clock line, index 1 the data line.
   logic [1:0]    line_s;
   logic [1:0]    meta_r;
   logic [1:0]    sync_r;
   logic [1:0]    filt_r;
   logic [FW-1:0] fcnt_r [2];
   logic          clk_prev_r;
   logic          fall_s;
   logic          data_s;

   // Frame receiver.
   state_t        state_r;
   state_t        state_nxt_s;
   logic [2:0]    bit_cnt_r;
   logic [7:0]    shreg_r;
   logic          par_r;
   logic [TW-1:0] timer_r;
   logic          timeout_s;
   logic          shift_s;
   logic          par_en_s;
   logic          good_s;
   logic          bad_s;
   logic          err_s;

   // Registered outputs and prefix flags.
   logic [10:0]   key_r;
   logic          key_strobe_r;
   logic [7:0]    rx_byte_r;
   logic          rx_strobe_r;
   logic          err_r;
   logic          ext_r;
   logic          rel_r;

   assign line_s = {ps2_data_in, ps2_clk_in};

   // Two-stage synchroniser on both lines, preset to the idle-high level.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         meta_r <= 2'b11;
         sync_r <= 2'b11;
      end else begin
         meta_r <= line_s;
         sync_r <= meta_r;
      end
   end

   // Glitch filter: a new level must persist FILTER_LEN samples to pass.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         filt_r     <= 2'b11;
         fcnt_r[0]  <= {FW{1'b0}};
         fcnt_r[1]  <= {FW{1'b0}};
         clk_prev_r <= 1'b1;
      end else begin
         clk_prev_r <= filt_r[0];
         for (int i = 0; i < 2; i++) begin
            if (sync_r[i] == filt_r[i]) begin
               fcnt_r[i] <= {FW{1'b0}};
            end else if (fcnt_r[i] == FILT_MAX) begin
               filt_r[i] <= sync_r[i];
               fcnt_r[i] <= {FW{1'b0}};
            end else begin
               fcnt_r[i] <= fcnt_r[i] + FW'(1);
            end
         end
      end
   end

   assign fall_s    = clk_prev_r & ~filt_r[0];
   assign data_s    = filt_r[1];
   // A fall on the very cycle the watchdog expires still counts as progress.
   assign timeout_s = (state_r != IDLE) && !fall_s && (timer_r == TMO_MAX);

   // FSM state register.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state: every advance happens on a filtered clock fall.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (fall_s && !data_s) state_nxt_s = DATA;
            else                   state_nxt_s = IDLE;
         end
         DATA: begin
            if (timeout_s)                           state_nxt_s = IDLE;
            else if (fall_s && (bit_cnt_r == 3'd7))  state_nxt_s = PARITY;
            else                                     state_nxt_s = DATA;
         end
         PARITY: begin
            if (timeout_s)   state_nxt_s = IDLE;
            else if (fall_s) state_nxt_s = STOP;
            else             state_nxt_s = PARITY;
         end
         STOP: begin
            if (timeout_s || fall_s) state_nxt_s = IDLE;
            else                     state_nxt_s = STOP;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM output decode: datapath enables and frame verdicts.
   always_comb begin
      shift_s  = 1'b0;
      par_en_s = 1'b0;
      good_s   = 1'b0;
      bad_s    = 1'b0;
      err_s    = 1'b0;
      case (state_r)
         IDLE: begin
            // A fall with data high cannot be a start bit.
            if (fall_s && data_s) err_s = 1'b1;
            else                  err_s = 1'b0;
         end
         DATA: begin
            shift_s = fall_s;
         end
         PARITY: begin
            par_en_s = fall_s;
         end
         STOP: begin
            if (fall_s && data_s && odd_parity_ok(shreg_r, par_r)) good_s = 1'b1;
            else if (fall_s)                                        bad_s  = 1'b1;
            else                                                    bad_s  = 1'b0;
         end
         default: begin
            shift_s = 1'b0;
         end
      endcase
      bad_s = bad_s | timeout_s;
      err_s = err_s | bad_s;
   end

   // Frame datapath: bit counter, shift register, parity latch, watchdog.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt_r <= 3'd0;
         shreg_r   <= 8'h00;
         par_r     <= 1'b0;
         timer_r   <= {TW{1'b0}};
      end else begin
         if (state_r == IDLE) bit_cnt_r <= 3'd0;
         else if (shift_s)    bit_cnt_r <= bit_cnt_r + 3'd1;

         if (shift_s) shreg_r <= {data_s, shreg_r[7:1]};
         if (par_en_s) par_r <= data_s;

         if ((state_r == IDLE) || fall_s || timeout_s) timer_r <= {TW{1'b0}};
         else                                          timer_r <= timer_r + TW'(1);
      end
   end

   // Byte delivery, prefix folding and one-cycle strobes.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         key_r        <= 11'h000;
         key_strobe_r <= 1'b0;
         rx_byte_r    <= 8'h00;
         rx_strobe_r  <= 1'b0;
         err_r        <= 1'b0;
         ext_r        <= 1'b0;
         rel_r        <= 1'b0;
      end else begin
         key_strobe_r <= 1'b0;
         rx_strobe_r  <= 1'b0;
         err_r        <= err_s;
         if (good_s) begin
            rx_byte_r   <= shreg_r;
            rx_strobe_r <= 1'b1;
            if (shreg_r == 8'hE0) begin
               ext_r <= 1'b1;
            end else if (shreg_r == 8'hF0) begin
               rel_r <= 1'b1;
            end else begin
               key_r        <= {~key_r[10], ~rel_r, ext_r, shreg_r};
               key_strobe_r <= 1'b1;
               ext_r        <= 1'b0;
               rel_r        <= 1'b0;
            end
         end else if (bad_s) begin
            ext_r <= 1'b0;
            rel_r <= 1'b0;
         end
      end
   end

   assign key_if.ps2_key    = key_r;
   assign key_if.key_strobe = key_strobe_r;
   assign key_if.rx_byte    = rx_byte_r;
   assign key_if.rx_strobe  = rx_strobe_r;
   assign key_if.frame_err  = err_r;

endmodule
